// File: rtl/cordic_engine.sv
// cordic_engine: iterative rotation/vectoring CORDIC with valid/ready
// handshakes, quadrant pre-correction and an elaboration-time atan ROM.
module cordic_engine #(
    parameter int DATA_W  = 32,
    parameter int ANGLE_W = 32,
    parameter int ITER    = 16,
    parameter int GUARD   = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      mode,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [DATA_W-1:0]  in_x,
    input  logic signed [DATA_W-1:0]  in_y,
    input  logic signed [ANGLE_W-1:0] in_z,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [DATA_W-1:0]  out_x,
    output logic signed [DATA_W-1:0]  out_y,
    output logic signed [ANGLE_W-1:0] out_z,
    output logic                      busy
);

    localparam int IW = DATA_W + GUARD;
    localparam int CW = $clog2(ITER);
    localparam logic [CW-1:0] LAST = CW'(ITER - 1);

    localparam logic signed [ANGLE_W-1:0] QTR =
        {2'b01, {(ANGLE_W-2){1'b0}}};
    localparam logic signed [ANGLE_W-1:0] NQTR =
        {2'b11, {(ANGLE_W-2){1'b0}}};
    localparam logic [ANGLE_W-1:0] HALF =
        {1'b1, {(ANGLE_W-1){1'b0}}};

    localparam real PI = 3.14159265358979323846;

    // atan(2^-i) in binary angle units; series form keeps it
    // to plain real arithmetic at elaboration time
    function automatic logic [ANGLE_W-1:0] atan_entry(input int i);
        real t;
        real t2;
        real term;
        real sum;
        real sgn;
        real scale;
        t = 1.0;
        for (int k = 0; k < i; k++) t = t / 2.0;
        if (i == 0) begin
            sum = PI / 4.0;
        end else begin
            t2   = t * t;
            term = t;
            sum  = 0.0;
            sgn  = 1.0;
            for (int k = 0; k < 40; k++) begin
                sum  = sum + sgn * term / real'(2 * k + 1);
                term = term * t2;
                sgn  = -sgn;
            end
        end
        scale = 1.0;
        for (int k = 0; k < ANGLE_W - 1; k++) scale = scale * 2.0;
        return ANGLE_W'(longint'(sum / PI * scale));
    endfunction

    // clamp an internal value into the output range
    function automatic logic signed [DATA_W-1:0] sat(
        input logic signed [IW-1:0] v
    );
        logic [IW-DATA_W:0] top;
        top = v[IW-1:DATA_W-1];
        if (&top || ~|top) return v[DATA_W-1:0];
        if (v[IW-1]) return {1'b1, {(DATA_W-1){1'b0}}};
        return {1'b0, {(DATA_W-1){1'b1}}};
    endfunction

    logic [ANGLE_W-1:0] atan_rom [ITER];

    for (genvar g = 0; g < ITER; g++) begin : g_rom
        localparam logic [ANGLE_W-1:0] ENTRY = atan_entry(g);
        assign atan_rom[g] = ENTRY;
    end

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t                    state;
    logic [CW-1:0]             cnt;
    logic                      mode_q;
    logic signed [IW-1:0]      x_q;
    logic signed [IW-1:0]      y_q;
    logic signed [ANGLE_W-1:0] z_q;

    logic signed [IW-1:0]      x_ext;
    logic signed [IW-1:0]      y_ext;
    logic signed [IW-1:0]      x_ld;
    logic signed [IW-1:0]      y_ld;
    logic signed [ANGLE_W-1:0] z_ld;

    logic signed [IW-1:0]      x_sh;
    logic signed [IW-1:0]      y_sh;
    logic signed [IW-1:0]      x_nx;
    logic signed [IW-1:0]      y_nx;
    logic signed [ANGLE_W-1:0] z_nx;
    logic signed [ANGLE_W-1:0] a_i;
    logic                      d_pos;

    // quadrant pre-correction so the micro-rotations only
    // ever have to cover +-pi/2
    always_comb begin
        x_ext = {{GUARD{in_x[DATA_W-1]}}, in_x};
        y_ext = {{GUARD{in_y[DATA_W-1]}}, in_y};
        x_ld  = x_ext;
        y_ld  = y_ext;
        z_ld  = in_z;
        if (mode) begin
            if (in_x[DATA_W-1]) begin
                x_ld = -x_ext;
                y_ld = -y_ext;
                z_ld = in_z + HALF;
            end
        end else if (in_z > QTR) begin
            x_ld = -y_ext;
            y_ld = x_ext;
            z_ld = in_z - QTR;
        end else if (in_z < NQTR) begin
            x_ld = y_ext;
            y_ld = -x_ext;
            z_ld = in_z + QTR;
        end
    end

    // one micro-rotation for the current counter value
    always_comb begin
        a_i   = atan_rom[cnt];
        x_sh  = x_q >>> cnt;
        y_sh  = y_q >>> cnt;
        d_pos = mode_q ? y_q[IW-1] : ~z_q[ANGLE_W-1];
        if (d_pos) begin
            x_nx = x_q - y_sh;
            y_nx = y_q + x_sh;
            z_nx = z_q - a_i;
        end else begin
            x_nx = x_q + y_sh;
            y_nx = y_q - x_sh;
            z_nx = z_q + a_i;
        end
    end

    // control FSM with registered handshake flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            mode_q    <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else if (en) begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        state    <= RUN;
                        cnt      <= '0;
                        mode_q   <= mode;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                RUN: begin
                    if (cnt == LAST) begin
                        state     <= DONE;
                        cnt       <= '0;
                        out_valid <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // working registers and the saturated result capture
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_q   <= '0;
            y_q   <= '0;
            z_q   <= '0;
            out_x <= '0;
            out_y <= '0;
            out_z <= '0;
        end else if (en) begin
            if (state == IDLE && in_valid) begin
                x_q <= x_ld;
                y_q <= y_ld;
                z_q <= z_ld;
            end else if (state == RUN) begin
                x_q <= x_nx;
                y_q <= y_nx;
                z_q <= z_nx;
                if (cnt == LAST) begin
                    out_x <= sat(x_nx);
                    out_y <= sat(y_nx);
                    out_z <= z_nx;
                end
            end
        end
    end

endmodule
